// File: rtl/stream_demux_1ton_if.sv
// -----------------------------------------------------------------------------
// stream_demux_1ton_if
//
// Purpose:
//   Bundles the producer-side valid/ready stream and the NUM_OUT consumer-side
//   channels of stream_demux_1ton into one interface.
//
// Parameters:
//   DATA_W   payload width in bits
//   NUM_OUT  number of output channels
//   SEL_W    derived select width, $clog2(NUM_OUT)
//
// Signals:
//   in_valid / in_ready / in_data / in_last / in_sel   producer stream
//   out_valid / out_ready / out_data / out_last        per-channel streams
//                                                      (channel i at
//                                                      [i*DATA_W +: DATA_W])
//   err_sel                                            dropped-packet pulse
//   beat_cnt                                           16-bit delivered-beat
//                                                      counter per channel
//
// Modports:
//   master  environment side: drives the producer stream and out_ready
//   slave   demux side: consumes the producer stream, drives the channels
// -----------------------------------------------------------------------------
interface stream_demux_1ton_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4
);
  localparam int SEL_W = $clog2(NUM_OUT);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_last;
  logic [SEL_W-1:0]          in_sel;

  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_last;

  logic                      err_sel;
  logic [NUM_OUT*16-1:0]     beat_cnt;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output in_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  err_sel,
    input  beat_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  in_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output err_sel,
    output beat_cnt
  );
endinterface

// File: rtl/stream_demux_1ton.sv
// -----------------------------------------------------------------------------
// stream_demux_1ton
//
// Purpose:
//   Routes one valid/ready input stream to one of NUM_OUT output channels,
//   packet by packet. The destination is taken from in_sel on the head beat of
//   a packet and held until its in_last beat. Each channel has its own
//   one-deep registered output stage, so channels drain independently and a
//   channel that is drained and refilled on the same edge sustains one beat
//   per cycle. Packets whose head selects a non-existent channel are accepted
//   and discarded in full, with a one-cycle err_sel pulse.
//
// Parameters:
//   DATA_W   payload width (>= 1)
//   NUM_OUT  number of output channels (>= 2, any value)
//   SEL_W    derived select width, not overridable
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (release synchronously upstream)
//   bus   stream_demux_1ton_if.slave: input stream, output channels,
//         err_sel pulse and per-channel beat counters
//
// Build option:
//   STREAM_DEMUX_BEAT_CNT_EN  when defined, beat_cnt slice i counts
//                             out_valid[i] && out_ready[i] handshakes
//                             (16-bit, wrapping). When undefined, beat_cnt
//                             is tied to zero and no counter flops exist.
//
// X handling:
//   The output-stage update is written with masks and conditional operators
//   rather than if/case so that an unknown in_sel on a valid beat propagates
//   to out_valid instead of being silently resolved.
// -----------------------------------------------------------------------------
module stream_demux_1ton #(
  parameter  int DATA_W  = 8,
  parameter  int NUM_OUT = 4,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input logic                clk,
  input logic                rst,
  stream_demux_1ton_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // One extra bit so the range compare also works when NUM_OUT == 2**SEL_W.
  localparam logic [SEL_W:0]     NUM_OUT_C     = (SEL_W+1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] ONE_HOT_LSB_C = {{(NUM_OUT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,   // waiting for a head beat
    ST_ROUTE = 2'd1,   // mid-packet, beats go to lock_sel_r
    ST_DROP  = 2'd2    // mid-packet, beats are discarded
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e                    state_r;
  state_e                    state_nxt_s;
  logic [SEL_W-1:0]          lock_sel_r;
  logic [SEL_W-1:0]          lock_sel_nxt_s;
  logic                      err_sel_r;
  logic                      err_sel_nxt_s;

  logic [SEL_W-1:0]          eff_sel_s;
  logic                      in_range_s;
  logic [NUM_OUT-1:0]        sel_onehot_s;
  logic [NUM_OUT-1:0]        slot_free_vec_s;
  logic                      slot_free_s;
  logic                      in_ready_s;
  logic                      accept_s;
  logic                      route_accept_s;
  logic [NUM_OUT-1:0]        load_vec_s;

  logic [NUM_OUT-1:0]        out_valid_r;
  logic [NUM_OUT*DATA_W-1:0] out_data_r;
  logic [NUM_OUT-1:0]        out_last_r;

  // ---------------------------------------------------------------------------
  // Channel selection and flow control
  // ---------------------------------------------------------------------------
  // Mid-packet beats ignore in_sel and follow the channel locked at the head.
  assign eff_sel_s  = (state_r == ST_ROUTE) ? lock_sel_r : bus.in_sel;
  assign in_range_s = ({1'b0, eff_sel_s} < NUM_OUT_C);

  // An out-of-range select shifts the bit off the top and yields all zeros;
  // that case is handled separately through in_range_s.
  assign sel_onehot_s    = ONE_HOT_LSB_C << eff_sel_s;
  assign slot_free_vec_s = ~out_valid_r | bus.out_ready;
  assign slot_free_s     = |(sel_onehot_s & slot_free_vec_s);

  // Input ready: follows the selected slot, or always accepts beats to drop.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready_s = in_range_s ? slot_free_s : 1'b1;
      ST_ROUTE: in_ready_s = slot_free_s;
      ST_DROP:  in_ready_s = 1'b1;
      default:  in_ready_s = 1'b0;
    endcase
  end

  assign accept_s       = bus.in_valid & in_ready_s;
  assign route_accept_s = accept_s & in_range_s & (state_r != ST_DROP);
  assign load_vec_s     = sel_onehot_s & {NUM_OUT{route_accept_s}};

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  // Next-state, locked channel and error pulse decode.
  always_comb begin
    state_nxt_s    = state_r;
    lock_sel_nxt_s = lock_sel_r;
    err_sel_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (in_range_s) begin
            if (!bus.in_last) begin
              state_nxt_s    = ST_ROUTE;
              lock_sel_nxt_s = bus.in_sel;
            end else begin
              state_nxt_s    = ST_IDLE;
            end
          end else begin
            err_sel_nxt_s = 1'b1;
            if (!bus.in_last) begin
              state_nxt_s = ST_DROP;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ROUTE, ST_DROP: begin
        if (accept_s && bus.in_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, locked channel and err_sel pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lock_sel_r <= {SEL_W{1'b0}};
      err_sel_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lock_sel_r <= lock_sel_nxt_s;
      err_sel_r  <= err_sel_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stages
  // ---------------------------------------------------------------------------
  // Per-channel one-deep registers: load on a routed accept, otherwise hold
  // while stalled and clear valid once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= {NUM_OUT{1'b0}};
      out_data_r  <= {(NUM_OUT*DATA_W){1'b0}};
      out_last_r  <= {NUM_OUT{1'b0}};
    end else begin
      out_valid_r <= load_vec_s | (out_valid_r & ~bus.out_ready);
      out_last_r  <= (load_vec_s & {NUM_OUT{bus.in_last}}) |
                     (~load_vec_s & out_last_r);
      for (int i = 0; i < NUM_OUT; i++) begin
        out_data_r[i*DATA_W +: DATA_W] <= load_vec_s[i] ? bus.in_data
                                                        : out_data_r[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delivered-beat counters
  // ---------------------------------------------------------------------------
`ifdef STREAM_DEMUX_BEAT_CNT_EN
  logic [NUM_OUT-1:0]    drain_vec_s;
  logic [NUM_OUT*16-1:0] beat_cnt_r;

  assign drain_vec_s = out_valid_r & bus.out_ready;

  // One 16-bit wrapping counter per channel, stepped on each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= {(NUM_OUT*16){1'b0}};
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        beat_cnt_r[i*16 +: 16] <= beat_cnt_r[i*16 +: 16] + {15'd0, drain_vec_s[i]};
      end
    end
  end

  assign bus.beat_cnt = beat_cnt_r;
`else
  assign bus.beat_cnt = {(NUM_OUT*16){1'b0}};
`endif

  // ---------------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.err_sel   = err_sel_r;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1ton
//
// Directed bench for stream_demux_1ton. Instance ua uses NUM_OUT=4 and
// instance ub uses NUM_OUT=5 (to reach out-of-range selects); both share one
// clock and reset. Inputs change 1 time unit after the rising edge, and all
// observations are made 1 or 2 time units after the edge.
// -----------------------------------------------------------------------------
module tb_stream_demux_1ton;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  stream_demux_1ton_if #(.DATA_W(8), .NUM_OUT(4)) a ();
  stream_demux_1ton_if #(.DATA_W(8), .NUM_OUT(5)) b ();

  stream_demux_1ton #(.DATA_W(8), .NUM_OUT(4)) ua (.clk(clk), .rst(rst), .bus(a.slave));
  stream_demux_1ton #(.DATA_W(8), .NUM_OUT(5)) ub (.clk(clk), .rst(rst), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic [1:0] s, input logic l);
    a.in_valid = v;
    a.in_data  = d;
    a.in_sel   = s;
    a.in_last  = l;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic [2:0] s, input logic l);
    b.in_valid = v;
    b.in_data  = d;
    b.in_sel   = s;
    b.in_last  = l;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    drive_b(1'b0, 8'h00, 3'd0, 1'b0);
    a.out_ready = 4'b1111;
    b.out_ready = 5'b11111;

    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_a_out_valid", a.out_valid, 4'b0000);
    chk("rst_a_out_data",  a.out_data,  32'h0);
    chk("rst_a_out_last",  a.out_last,  4'b0000);
    chk("rst_a_err_sel",   a.err_sel,   1'b0);
    chk("rst_a_beat_cnt",  a.beat_cnt,  64'h0);
    chk("rst_a_in_ready",  a.in_ready,  1'b1);
    chk("rst_b_out_valid", b.out_valid, 5'b00000);
    rst = 1'b0;
    step();

    // ---------------- single beats to every channel ----------------
    for (int s = 0; s < 4; s++) begin
      drive_a(1'b1, 8'hA0 + 8'(s), 2'(s), 1'b1);
      #1;
      chk("single_in_ready", a.in_ready, 1'b1);
      step();
      chk("single_out_valid", a.out_valid, 4'b0001 << s);
      chk("single_out_data",  a.out_data[s*8 +: 8], 8'hA0 + 8'(s));
      chk("single_out_last",  a.out_last[s], 1'b1);
      chk("single_err_sel",   a.err_sel, 1'b0);
    end
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    chk("single_drained", a.out_valid, 4'b0000);

    // ---------------- 3-beat packet locked to ch2 ----------------
    drive_a(1'b1, 8'h11, 2'd2, 1'b0);
    step();
    chk("pkt_b1_valid", a.out_valid, 4'b0100);
    chk("pkt_b1_data",  a.out_data[16 +: 8], 8'h11);
    chk("pkt_b1_last",  a.out_last[2], 1'b0);
    drive_a(1'b1, 8'h22, 2'd1, 1'b0);
    step();
    chk("pkt_b2_valid", a.out_valid, 4'b0100);
    chk("pkt_b2_data",  a.out_data[16 +: 8], 8'h22);
    chk("pkt_b2_last",  a.out_last[2], 1'b0);
    drive_a(1'b1, 8'h33, 2'd1, 1'b1);
    step();
    chk("pkt_b3_valid", a.out_valid, 4'b0100);
    chk("pkt_b3_data",  a.out_data[16 +: 8], 8'h33);
    chk("pkt_b3_last",  a.out_last[2], 1'b1);
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    chk("pkt_drained", a.out_valid, 4'b0000);

    // ---------------- backpressure on ch1 ----------------
    a.out_ready = 4'b1101;
    drive_a(1'b1, 8'h55, 2'd1, 1'b0);
    #1;
    chk("bp_first_ready", a.in_ready, 1'b1);
    step();
    chk("bp_first_valid", a.out_valid, 4'b0010);
    chk("bp_first_data",  a.out_data[8 +: 8], 8'h55);
    // Next beat carries in_sel=0, which must be ignored mid-packet.
    drive_a(1'b1, 8'h66, 2'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_ready", a.in_ready, 1'b0);
      chk("bp_hold_valid", a.out_valid, 4'b0010);
      chk("bp_hold_data",  a.out_data[8 +: 8], 8'h55);
      step();
    end
    a.out_ready = 4'b1111;
    #1;
    chk("bp_release_ready", a.in_ready, 1'b1);
    step();
    chk("bp_beat2_valid", a.out_valid, 4'b0010);
    chk("bp_beat2_data",  a.out_data[8 +: 8], 8'h66);
    chk("bp_beat2_last",  a.out_last[1], 1'b0);
    drive_a(1'b1, 8'h77, 2'd0, 1'b1);
    #1;
    chk("bp_beat3_ready", a.in_ready, 1'b1);
    step();
    chk("bp_beat3_valid", a.out_valid, 4'b0010);
    chk("bp_beat3_data",  a.out_data[8 +: 8], 8'h77);
    chk("bp_beat3_last",  a.out_last[1], 1'b1);
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    chk("bp_drained", a.out_valid, 4'b0000);

    // ---------------- out-of-range select on the 5-channel instance --------
    drive_b(1'b1, 8'hE1, 3'd6, 1'b0);
    #1;
    chk("drop_b1_ready", b.in_ready, 1'b1);
    step();
    chk("drop_b1_err",   b.err_sel, 1'b1);
    chk("drop_b1_valid", b.out_valid, 5'b00000);
    drive_b(1'b1, 8'hE2, 3'd4, 1'b1);
    #1;
    chk("drop_b2_ready", b.in_ready, 1'b1);
    step();
    chk("drop_b2_err",   b.err_sel, 1'b0);
    chk("drop_b2_valid", b.out_valid, 5'b00000);
    drive_b(1'b1, 8'h44, 3'd4, 1'b1);
    #1;
    chk("ch4_ready", b.in_ready, 1'b1);
    step();
    chk("ch4_valid", b.out_valid, 5'b10000);
    chk("ch4_data",  b.out_data[32 +: 8], 8'h44);
    chk("ch4_last",  b.out_last[4], 1'b1);
    chk("ch4_err",   b.err_sel, 1'b0);
    drive_b(1'b0, 8'h00, 3'd0, 1'b0);
    step();
    chk("ch4_drained", b.out_valid, 5'b00000);

    // ---------------- reset mid-packet ----------------
    a.out_ready = 4'b0111;
    drive_a(1'b1, 8'h77, 2'd3, 1'b0);
    step();
    chk("mid_ch3_valid", a.out_valid, 4'b1000);
    chk("mid_ch3_data",  a.out_data[24 +: 8], 8'h77);
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", a.out_valid, 4'b0000);
    chk("async_rst_data",  a.out_data,  32'h0);
    chk("async_rst_last",  a.out_last,  4'b0000);
    chk("async_rst_err",   a.err_sel,   1'b0);
    step();
    rst = 1'b0;
    a.out_ready = 4'b1111;
    drive_a(1'b1, 8'h88, 2'd0, 1'b1);
    #1;
    chk("post_rst_ready", a.in_ready, 1'b1);
    step();
    chk("post_rst_valid", a.out_valid, 4'b0001);
    chk("post_rst_data",  a.out_data[7:0], 8'h88);
    chk("post_rst_last",  a.out_last[0], 1'b1);
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    chk("post_rst_drained", a.out_valid, 4'b0000);

    // ---------------- beat counters ----------------
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("cnt_cleared", a.beat_cnt, 64'h0);
    for (int n = 0; n < 70000; n++) begin
      drive_a(1'b1, 8'(n), 2'd0, 1'b1);
      step();
    end
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    chk("cnt_ch0_wrap", a.beat_cnt[15:0],  16'd4464);
    chk("cnt_ch1",      a.beat_cnt[31:16], 16'd0);
    chk("cnt_ch2",      a.beat_cnt[47:32], 16'd0);
    chk("cnt_ch3",      a.beat_cnt[63:48], 16'd0);
`else
    chk("cnt_off_a", a.beat_cnt, 64'h0);
    chk("cnt_off_b", b.beat_cnt, 80'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
Parametrised successor of the level-0 1:4 combinational demux. It routes a valid/ready input stream to one of NUM_OUT output channels, each with its own registered output stage. The route is chosen per packet: `in_sel` is sampled on the first beat and held until the `in_last` beat. The block is used wherever one producer stream fans out to several consumers with independent backpressure.

Parameters:
- DATA_W, 8, payload width in bits (≥1)
- NUM_OUT, 4, number of output channels (≥2; need not be a power of two)
- SEL_W, $clog2(NUM_OUT), select width; derived, not overridden

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DATA_W  input payload
- in_last  in  1  final beat of packet
- in_sel  in  SEL_W  destination channel; sampled only on a packet's first beat
- out_valid  out  NUM_OUT  per-channel valid
- out_ready  in  NUM_OUT  per-channel ready
- out_data  out  NUM_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- out_last  out  NUM_OUT  per-channel last
- err_sel  out  1  one-cycle pulse: a packet was dropped for out-of-range in_sel
- beat_cnt  out  NUM_OUT*16  per-channel delivered-beat counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid, out_data, out_last, err_sel and beat_cnt are all 0. Any in-flight beat is discarded. A packet interrupted by reset is not resumed; the next accepted beat is a head beat.
- FSM states: IDLE (awaiting head beat), ROUTE (mid-packet to locked channel), DROP (mid-packet, discarding).
- Effective select: eff_sel = in_sel in IDLE, lock_sel in ROUTE.
- Channel slot free = !out_valid[eff_sel] || out_ready[eff_sel].
- in_ready, combinational:
  - IDLE with in_sel<NUM_OUT: slot free.
  - IDLE with in_sel≥NUM_OUT: 1.
  - ROUTE: slot free.
  - DROP: 1.
- Accepted routed beat: out_data/out_last of channel eff_sel load in_data/in_last next edge; out_valid[eff_sel] is set. Latency is 1 cycle from accept to out_valid.
- Output hold: while out_valid[i] && !out_ready[i], out_data/out_last of channel i stay stable. Other channels drain independently.
- Simultaneous drain and refill on the same channel: out_valid stays 1 and data updates. Full throughput is 1 beat/cycle.
- Drain without refill: out_valid[i] clears next edge.
- Transitions:
  - IDLE, head accepted, in_sel<NUM_OUT, !in_last → ROUTE, lock_sel=in_sel.
  - IDLE, head accepted, in_sel≥NUM_OUT → err_sel=1 for one cycle; → DROP if !in_last, else stay IDLE. The beat is discarded.
  - ROUTE or DROP, beat accepted with in_last → IDLE.
  - Single-beat packet (head with in_last) → stays IDLE.
- in_sel changes during ROUTE/DROP are ignored.
- With in_valid low, nothing is loaded and state is unchanged; in_ready may still be high.
- Unused/invalid in_sel X with in_valid=1: out_valid of all channels goes X (X-propagation required; no X masking).

Optional Feature:
- Macro: STREAM_DEMUX_BEAT_CNT_EN.
- Defined: beat_cnt slice i is a 16-bit counter that increments on each out_valid[i]&&out_ready[i] handshake and wraps 0xFFFF→0x0000. It is cleared by rst.
- Undefined: beat_cnt is driven constant 0 and no counter flops are inferred.

Test Plan:
- NUM_OUT=4, DATA_W=8: single beats 0xA0..0xA3 with in_sel=0..3, in_last=1, all out_ready=1 → each appears on its own channel 1 cycle later; other out_valid stay 0.
- 3-beat packet 0x11,0x22,0x33 with in_sel=2 on the head and in_sel=1 on the later beats → all three beats on ch2; out_last[2]=1 only with 0x33; ch1 sees nothing.
- out_ready[1]=0 for 5 cycles while streaming to ch1 → in_ready=0 after the first beat and out_data ch1 holds 0x55. A concurrent next packet cannot start until release. Releasing out_ready[1] resumes 1 beat/cycle with no loss or duplication.
- NUM_OUT=5 instance, 2-beat packet with in_sel=6 → err_sel high exactly 1 cycle, both beats accepted (in_ready=1), no out_valid. The following packet with in_sel=4 is delivered normally.
- rst asserted mid-packet (ch3 holding 0x77, state ROUTE) → all outputs 0 immediately, no clock needed. After release, the next beat with in_sel=0 routes to ch0.
- With STREAM_DEMUX_BEAT_CNT_EN: 70000 beats to ch0 → beat_cnt[15:0]=70000 mod 65536=4464, other slices 0. Without the macro, beat_cnt stays 0.
